video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the HDMI/DVI output path; it drives the three TMDS encoders.
//  Generates H/V sync and DE with programmable polarity, plus a pixel request that runs REQ_LEAD cycles
//  ahead of DE, with X/Y coordinates, so frame-buffer readers with fixed latency can feed it.
//  Returns fetched RGB realigned to DE and forced to zero in blanking. Also gives frame and line strobes.
// PARAMETERS
//  CW        12     counter width; HTOTAL-1 and VTOTAL-1 must fit, else elaboration $error
//  HAPIX     800    active pixels per line
//  HFPOR     48     horizontal front porch (clocks)
//  HSPUL     32     horizontal sync pulse (clocks)
//  HBPOR     80     horizontal back porch (clocks)
//  VAPIX     600    active lines
//  VFPOR     3      vertical front porch (lines)
//  VSPUL     4      vertical sync pulse (lines)
//  VBPOR     29     vertical back porch (lines)
//  HS_POL    0      asserted level of SYNC_H (0 = active-low)
//  VS_POL    0      asserted level of SYNC_V
//  REQ_LEAD  2      clocks from oRequest to matching DE; legal range 1..16
//  BAR_W     100    colour-bar width in pixels (only with PATTERN_EN)
// PORTS
//  clock_pixel  in   1   pixel clock; every flop is clocked on the rising edge
//  reset        in   1   asynchronous active-high reset
//  run          in   1   1 = raster runs; 0 = hold idle
//  iRed/iGreen/iBlue  in  8 each  fetched pixel data (see BEHAVIOUR)
//  oRequest     out  1   pixel fetch request, one per active pixel
//  oReqX        out  CW  X of requested pixel, valid while oRequest = 1
//  oReqY        out  CW  Y of requested pixel, valid while oRequest = 1
//  SYNC_H       out  1   horizontal sync, aligned with DE
//  SYNC_V       out  1   vertical sync, aligned with DE
//  DE           out  1   data enable
//  oRed/oGreen/oBlue  out  8 each  pixel to TMDS encoders; 0 when DE = 0
//  oFrameStart  out  1   1-clk pulse aligned to the first DE of a frame
//  oLineStart   out  1   1-clk pulse aligned to the first DE of each active line
//  iPattern     in   1   (PATTERN_EN only) 1 = internal colour bars replace iRGB
// BEHAVIOUR
//  - HTOTAL = HAPIX+HFPOR+HSPUL+HBPOR and VTOTAL likewise. Counters cx and cy both reset to 0.
//  - cx wraps at HTOTAL-1. cy increments on cx wrap and wraps at VTOTAL-1 to 0.
//  - Request stage (registered): in cycle n+1, oRequest = (cx<HAPIX && cy<VAPIX), with oReqX/oReqY = cx/cy of cycle n.
//  - Display stage: the request-stage flags go through a REQ_LEAD-deep shift register.
//    DE, SYNC_H and SYNC_V for a counter position appear exactly REQ_LEAD clocks after its oRequest.
//  - SYNC_H is asserted for HAPIX+HFPOR <= cx < HAPIX+HFPOR+HSPUL. SYNC_V uses the same rule on cy.
//  - Data handshake: for oRequest high in cycle n, iRGB is sampled at the edge closing cycle n+REQ_LEAD-1.
//    oRGB is registered and shows that pixel in cycle n+REQ_LEAD, together with DE. No back-pressure.
//  - oRGB = 0 in every cycle where DE = 0, whatever iRGB is.
//  - oFrameStart and oLineStart are delayed through the same pipe as DE.
//  - run = 0: counters held at (0,0), pipe flushed to idle.
//    Idle means oRequest = 0, DE = 0, oRGB = 0, syncs at de-asserted level (~HS_POL, ~VS_POL).
//  - run 0->1: the first oRequest is at (0,0), one clock after the first cycle with run = 1.
//  - Dropping run mid-frame aborts immediately, with the same effect as a synchronous reset to idle.
//  - Reset outputs: as idle above, oFrameStart = oLineStart = 0. Reset acts asynchronously, mid-frame included.
// CONFIGURATION
//  - `VIDEO_PATTERN_EN defined: adds port iPattern and a colour-bar generator in the display stage.
//    The bar counter restarts at every line start and advances every BAR_W pixels.
//    Bar order: white, yellow, cyan, green, magenta, red, blue, black, then repeat. Components are 8'hFF or 8'h00.
//    With iPattern = 1, oRGB = bar colour and iRGB is ignored; oRequest is unchanged.
//  - `VIDEO_PATTERN_EN undefined: no iPattern port, no bar logic, oRGB always comes from iRGB.
// STRUCTURE
//  - Package video_timing_pkg holds typedef timing_t (8 fields HAPIX..VBPOR).
//    It also holds constants SVGA_120_RB, SVGA_60, FWVGA_60 and FWVGA_120_RB (the timing sets above).
//  - One sub-module, video_raster_cnt: cx/cy counters with run/wrap, providing active/hsync/vsync/line/frame flags.
//  - The top level keeps the REQ_LEAD pipe, data alignment, blanking and optional pattern logic.
// TESTING (bench params: H 8/2/3/3 -> HTOTAL 16; V 4/1/2/1 -> VTOTAL 8; REQ_LEAD 3)
//  - Reset, then run = 1: first oRequest with (X,Y) = (0,0) one clock later. DE rises 3 clocks after that.
//    Per line: 8 requests, 8 DE clocks; frame period exactly 128 clocks.
//  - Return iRGB = {X,Y,X^Y} two clocks after each request: oRGB matches it in the DE cycle.
//    iRGB = 8'hAA during blanking: oRGB = 0.
//  - Sync check, HS_POL = VS_POL = 0: SYNC_H low for 3 clocks starting 2 clocks after DE falls.
//    SYNC_V low for 32 clocks, covering lines 5-6.
//  - Drop run at line 2 px 5: one clock later all outputs idle. Restart: clean frame from (0,0) with oFrameStart.
//  - Assert reset asynchronously mid-line: outputs idle before the next clock edge. Release: same as run restart.
//  - `VIDEO_PATTERN_EN, BAR_W = 2, iPattern = 1: each line gives white,white,yellow,yellow,cyan,cyan,green,green.
//    iRGB is ignored.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing types, standard mode sets and the pipeline flag bundle
// used by the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        int unsigned hapix;
        int unsigned hfpor;
        int unsigned hspul;
        int unsigned hbpor;
        int unsigned vapix;
        int unsigned vfpor;
        int unsigned vspul;
        int unsigned vbpor;
    } timing_t;

    localparam timing_t SVGA_120_RB = '{hapix: 800, hfpor: 48, hspul: 32, hbpor: 80,
                                        vapix: 600, vfpor: 3, vspul: 4, vbpor: 29};
    localparam timing_t SVGA_60     = '{hapix: 800, hfpor: 40, hspul: 128, hbpor: 88,
                                        vapix: 600, vfpor: 1, vspul: 4, vbpor: 23};
    localparam timing_t FWVGA_60    = '{hapix: 854, hfpor: 16, hspul: 80, hbpor: 96,
                                        vapix: 480, vfpor: 3, vspul: 10, vbpor: 7};
    localparam timing_t FWVGA_120_RB = '{hapix: 854, hfpor: 48, hspul: 32, hbpor: 80,
                                         vapix: 480, vfpor: 3, vspul: 10, vbpor: 8};

    // Per-position raster flags carried from the counters down the display pipe.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic line;
        logic frame;
    } flags_t;

    // Colour-bar order white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(logic [2:0] idx);
        return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
    endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// Raster position counters (cx, cy) held at the origin while run is low, with
// combinational decode of active area, sync windows and line/frame starts.
module video_raster_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned CW    = 12,
    parameter int unsigned HAPIX = 800,
    parameter int unsigned HFPOR = 48,
    parameter int unsigned HSPUL = 32,
    parameter int unsigned HBPOR = 80,
    parameter int unsigned VAPIX = 600,
    parameter int unsigned VFPOR = 3,
    parameter int unsigned VSPUL = 4,
    parameter int unsigned VBPOR = 29
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    output logic [CW-1:0] o_cx,
    output logic [CW-1:0] o_cy,
    output flags_t        o_flags
);

    localparam int unsigned HTOTAL = HAPIX + HFPOR + HSPUL + HBPOR;
    localparam int unsigned VTOTAL = VAPIX + VFPOR + VSPUL + VBPOR;
    localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);

    logic [CW-1:0] r_cx, r_cy;
    logic [31:0]   w_cx32, w_cy32;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (!i_run) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_cx == H_LAST) begin
            r_cx <= '0;
            r_cy <= (r_cy == V_LAST) ? '0 : r_cy + 1'b1;
        end else begin
            r_cx <= r_cx + 1'b1;
        end
    end

    // Decode in 32 bits so a sync window ending exactly at HTOTAL cannot wrap.
    assign w_cx32 = 32'(r_cx);
    assign w_cy32 = 32'(r_cy);

    always_comb begin
        o_flags.active = (w_cx32 < HAPIX) && (w_cy32 < VAPIX);
        o_flags.hsync  = (w_cx32 >= HAPIX + HFPOR) && (w_cx32 < HAPIX + HFPOR + HSPUL);
        o_flags.vsync  = (w_cy32 >= VAPIX + VFPOR) && (w_cy32 < VAPIX + VFPOR + VSPUL);
        o_flags.line   = (r_cx == '0) && (w_cy32 < VAPIX);
        o_flags.frame  = (r_cx == '0) && (r_cy == '0);
    end

    assign o_cx = r_cx;
    assign o_cy = r_cy;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel requests lead DE/syncs by REQ_LEAD clocks; fetched RGB is
// realigned to DE and blanked. Define VIDEO_PATTERN_EN to add iPattern and colour bars.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CW       = 12,
    parameter int unsigned HAPIX    = 800,
    parameter int unsigned HFPOR    = 48,
    parameter int unsigned HSPUL    = 32,
    parameter int unsigned HBPOR    = 80,
    parameter int unsigned VAPIX    = 600,
    parameter int unsigned VFPOR    = 3,
    parameter int unsigned VSPUL    = 4,
    parameter int unsigned VBPOR    = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned REQ_LEAD = 2,
    parameter int unsigned BAR_W    = 100
) (
    input  logic          clock_pixel,
    input  logic          reset,
    input  logic          run,
    input  logic [7:0]    iRed,
    input  logic [7:0]    iGreen,
    input  logic [7:0]    iBlue,
`ifdef VIDEO_PATTERN_EN
    input  logic          iPattern,
`endif
    output logic          oRequest,
    output logic [CW-1:0] oReqX,
    output logic [CW-1:0] oReqY,
    output logic          SYNC_H,
    output logic          SYNC_V,
    output logic          DE,
    output logic [7:0]    oRed,
    output logic [7:0]    oGreen,
    output logic [7:0]    oBlue,
    output logic          oFrameStart,
    output logic          oLineStart
);

    localparam int unsigned HTOTAL = HAPIX + HFPOR + HSPUL + HBPOR;
    localparam int unsigned VTOTAL = VAPIX + VFPOR + VSPUL + VBPOR;

    if ((((HTOTAL - 1) >> CW) != 0) || (((VTOTAL - 1) >> CW) != 0)) begin : g_cw_check
        $error("video_timing_gen: CW too narrow for HTOTAL-1 / VTOTAL-1");
    end
    if ((REQ_LEAD < 1) || (REQ_LEAD > 16)) begin : g_lead_check
        $error("video_timing_gen: REQ_LEAD must be within 1..16");
    end

    logic [CW-1:0] w_cx, w_cy;
    flags_t        w_flags;

    video_raster_cnt #(
        .CW    (CW),
        .HAPIX (HAPIX),
        .HFPOR (HFPOR),
        .HSPUL (HSPUL),
        .HBPOR (HBPOR),
        .VAPIX (VAPIX),
        .VFPOR (VFPOR),
        .VSPUL (VSPUL),
        .VBPOR (VBPOR)
    ) u_raster_cnt (
        .i_clk   (clock_pixel),
        .i_rst   (reset),
        .i_run   (run),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_flags (w_flags)
    );

    // Stage 0 is the request stage; stage REQ_LEAD drives DE and the syncs.
    flags_t        r_pipe [REQ_LEAD+1];
    logic [CW-1:0] r_req_x, r_req_y;
    logic [23:0]   r_rgb;
    logic [23:0]   w_src_rgb;

`ifdef VIDEO_PATTERN_EN
    logic [15:0] r_bar_px, w_bar_px;
    logic [2:0]  r_bar_idx, w_bar_idx;

    always_comb begin
        w_bar_px  = r_pipe[REQ_LEAD-1].line ? '0 : r_bar_px;
        w_bar_idx = r_pipe[REQ_LEAD-1].line ? '0 : r_bar_idx;
        w_src_rgb = iPattern ? bar_colour(w_bar_idx) : {iRed, iGreen, iBlue};
    end

    always_ff @(posedge clock_pixel or posedge reset) begin
        if (reset) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (!run) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (r_pipe[REQ_LEAD-1].active) begin
            if (32'(w_bar_px) == BAR_W - 1) begin
                r_bar_px  <= '0;
                r_bar_idx <= w_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= w_bar_px + 16'd1;
                r_bar_idx <= w_bar_idx;
            end
        end
    end
`else
    assign w_src_rgb = {iRed, iGreen, iBlue};
`endif

    always_ff @(posedge clock_pixel or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= int'(REQ_LEAD); i++) r_pipe[i] <= '0;
            r_req_x <= '0;
            r_req_y <= '0;
            r_rgb   <= '0;
        end else if (!run) begin
            for (int i = 0; i <= int'(REQ_LEAD); i++) r_pipe[i] <= '0;
            r_req_x <= '0;
            r_req_y <= '0;
            r_rgb   <= '0;
        end else begin
            r_pipe[0] <= w_flags;
            for (int i = 1; i <= int'(REQ_LEAD); i++) r_pipe[i] <= r_pipe[i-1];
            r_req_x <= w_cx;
            r_req_y <= w_cy;
            // Capture on the edge that moves this pixel's flags into the DE stage.
            r_rgb   <= r_pipe[REQ_LEAD-1].active ? w_src_rgb : '0;
        end
    end

    assign oRequest    = r_pipe[0].active;
    assign oReqX       = r_req_x;
    assign oReqY       = r_req_y;
    assign DE          = r_pipe[REQ_LEAD].active;
    assign SYNC_H      = r_pipe[REQ_LEAD].hsync ? HS_POL : ~HS_POL;
    assign SYNC_V      = r_pipe[REQ_LEAD].vsync ? VS_POL : ~VS_POL;
    assign oFrameStart = r_pipe[REQ_LEAD].frame;
    assign oLineStart  = r_pipe[REQ_LEAD].line;
    assign oRed        = r_rgb[23:16];
    assign oGreen      = r_rgb[15:8];
    assign oBlue       = r_rgb[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster; expected outputs come from a
// time-since-run-start model of raster position.
module tb_video_timing_gen;

    localparam int CW = 12;
    localparam int HAPIX = 8, HFPOR = 2, HSPUL = 3, HBPOR = 3;
    localparam int VAPIX = 4, VFPOR = 1, VSPUL = 2, VBPOR = 1;
    localparam int REQ_LEAD = 3;
    localparam int BAR_W = 2;
    localparam int HT = HAPIX + HFPOR + HSPUL + HBPOR;
    localparam int VT = VAPIX + VFPOR + VSPUL + VBPOR;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    localparam logic [29:0] IDLE = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

    typedef struct packed {
        logic          req;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } req_t;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic [23:0] rgb;
    } disp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [7:0]    ir, ig, ib;
    logic          oRequest, SYNC_H, SYNC_V, DE, oFrameStart, oLineStart;
    logic [CW-1:0] oReqX, oReqY;
    logic [7:0]    oRed, oGreen, oBlue;
`ifdef VIDEO_PATTERN_EN
    logic          pat;
`endif

    int       n_checks = 0;
    int       n_fail   = 0;
    int       k        = 0;    // consecutive edges with run high since last idle
    logic [7:0] salt   = 8'h00;
    bit       pat_mode = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CW       (CW),
        .HAPIX    (HAPIX),
        .HFPOR    (HFPOR),
        .HSPUL    (HSPUL),
        .HBPOR    (HBPOR),
        .VAPIX    (VAPIX),
        .VFPOR    (VFPOR),
        .VSPUL    (VSPUL),
        .VBPOR    (VBPOR),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0),
        .REQ_LEAD (REQ_LEAD),
        .BAR_W    (BAR_W)
    ) dut (
        .clock_pixel (clk),
        .reset       (rst),
        .run         (run),
        .iRed        (ir),
        .iGreen      (ig),
        .iBlue       (ib),
`ifdef VIDEO_PATTERN_EN
        .iPattern    (pat),
`endif
        .oRequest    (oRequest),
        .oReqX       (oReqX),
        .oReqY       (oReqY),
        .SYNC_H      (SYNC_H),
        .SYNC_V      (SYNC_V),
        .DE          (DE),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oFrameStart (oFrameStart),
        .oLineStart  (oLineStart)
    );

    function automatic int pos_x(int p);
        return p % HT;
    endfunction

    function automatic int pos_y(int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit pos_active(int p);
        return (pos_x(p) < HAPIX) && (pos_y(p) < VAPIX);
    endfunction

    function automatic logic [23:0] pix_of(int p);
        logic [7:0] x8, y8;
        x8 = 8'(pos_x(p));
        y8 = 8'(pos_y(p));
        if (pat_mode) return BARS[(pos_x(p) / BAR_W) % 8];
        return {x8, y8, x8 ^ y8 ^ salt};
    endfunction

    // Position p is requested at k = p+1 and displayed at k = p+1+REQ_LEAD.
    function automatic req_t exp_req(int kk);
        req_t r;
        int   p;
        p = kk - 1;
        r = '0;
        if (p >= 0 && pos_active(p)) begin
            r.req = 1'b1;
            r.x   = CW'(pos_x(p));
            r.y   = CW'(pos_y(p));
        end
        return r;
    endfunction

    function automatic disp_t exp_disp(int kk);
        disp_t d;
        int    p, x, y;
        p = kk - 1 - REQ_LEAD;
        d = IDLE[28:0];
        if (p >= 0) begin
            x     = pos_x(p);
            y     = pos_y(p);
            d.de  = pos_active(p);
            d.hs  = !(x >= HAPIX + HFPOR && x < HAPIX + HFPOR + HSPUL);
            d.vs  = !(y >= VAPIX + VFPOR && y < VAPIX + VFPOR + VSPUL);
            d.fs  = (x == 0) && (y == 0);
            d.ls  = (x == 0) && (y < VAPIX);
            d.rgb = d.de ? pix_of(p) : 24'h0;
        end
        return d;
    endfunction

    // Present the pixel due this cycle (or junk), advance one clock, land on the negedge.
    task automatic tick();
        int p;
        p = k - REQ_LEAD;
        if (p >= 0 && pos_active(p) && !pat_mode) {ir, ig, ib} = pix_of(p);
        else if ($urandom_range(0, 1) == 0) {ir, ig, ib} = 24'hAAAAAA;
        else {ir, ig, ib} = 24'($urandom);
        @(posedge clk);
        k = (run && !rst) ? k + 1 : 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [29:0] got;
        rst = 1'b1;
        run = 1'b1;
        {ir, ig, ib} = 24'($urandom);
        repeat (2) @(negedge clk);
        got = {oRequest, DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
        n_checks++;
        if (got !== IDLE) begin
            n_fail++;
            $display("FAIL reset_held: got %h, want %h", got, IDLE);
        end
        rst = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {oRequest, DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
            n_checks++;
            if (got !== IDLE) begin
                n_fail++;
                $display("FAIL run_low_idle: got %h, want %h", got, IDLE);
            end
        end
    endtask

    task automatic test_raster();
        req_t  er;
        disp_t ed, gd;
        salt = 8'($urandom);
        run  = 1'b1;
        for (int i = 0; i < 2 * FRAME + 24; i++) begin
            er = exp_req(k);
            ed = exp_disp(k);
            gd = {DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
            n_checks++;
            if (oRequest !== er.req || (er.req && (oReqX !== er.x || oReqY !== er.y))) begin
                n_fail++;
                $display("FAIL raster_req k=%0d: got %b (%0d,%0d), want %b (%0d,%0d)",
                         k, oRequest, oReqX, oReqY, er.req, er.x, er.y);
            end
            n_checks++;
            if (gd !== ed) begin
                n_fail++;
                $display("FAIL raster_disp k=%0d: got %h, want %h", k, gd, ed);
            end
            tick();
        end
    endtask

    task automatic test_frame_period();
        int first, second, period, n_de, n_req, n_vs, n_hs, n_ls;
        first = -1; second = -1;
        n_de = 0; n_req = 0; n_vs = 0; n_hs = 0; n_ls = 0;
        for (int i = 0; i < 3 * FRAME && second < 0; i++) begin
            if (oFrameStart) begin
                if (first < 0) first = i;
                else second = i;
            end
            if (first >= 0 && second < 0) begin
                n_de  += int'(DE);
                n_req += int'(oRequest);
                n_vs  += int'(!SYNC_V);
                n_hs  += int'(!SYNC_H);
                n_ls  += int'(oLineStart);
            end
            tick();
        end
        period = (second >= 0) ? second - first : -1;
        n_checks++;
        if (period != FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d, want %0d", period, FRAME);
        end
        n_checks++;
        if (n_de != HAPIX * VAPIX) begin
            n_fail++;
            $display("FAIL de_per_frame: got %0d, want %0d", n_de, HAPIX * VAPIX);
        end
        n_checks++;
        if (n_req != HAPIX * VAPIX) begin
            n_fail++;
            $display("FAIL req_per_frame: got %0d, want %0d", n_req, HAPIX * VAPIX);
        end
        n_checks++;
        if (n_vs != VSPUL * HT) begin
            n_fail++;
            $display("FAIL vsync_low_clocks: got %0d, want %0d", n_vs, VSPUL * HT);
        end
        n_checks++;
        if (n_hs != HSPUL * VT) begin
            n_fail++;
            $display("FAIL hsync_low_clocks: got %0d, want %0d", n_hs, HSPUL * VT);
        end
        n_checks++;
        if (n_ls != VAPIX) begin
            n_fail++;
            $display("FAIL line_starts: got %0d, want %0d", n_ls, VAPIX);
        end
    endtask

    task automatic test_run_drop();
        req_t  er;
        disp_t ed, gd;
        int    off;
        off = $urandom_range(1, 5);
        for (int i = 0; i < 2 * FRAME && (k % FRAME) != 2 * HT + 5; i++) tick();
        run = 1'b0;
        for (int i = 0; i < FRAME + 24; i++) begin
            if (i == off + 1) run = 1'b1;
            er = exp_req(k);
            ed = exp_disp(k);
            gd = {DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
            n_checks++;
            if (oRequest !== er.req || (er.req && (oReqX !== er.x || oReqY !== er.y))) begin
                n_fail++;
                $display("FAIL run_drop_req i=%0d k=%0d: got %b (%0d,%0d), want %b (%0d,%0d)",
                         i, k, oRequest, oReqX, oReqY, er.req, er.x, er.y);
            end
            n_checks++;
            if (gd !== ed) begin
                n_fail++;
                $display("FAIL run_drop_disp i=%0d k=%0d: got %h, want %h", i, k, gd, ed);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        req_t        er;
        disp_t       ed, gd;
        logic [29:0] got;
        int          skip;
        skip = $urandom_range(20, 100);
        for (int i = 0; i < skip; i++) tick();
        #2 rst = 1'b1;
        #1;
        got = {oRequest, DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
        n_checks++;
        if (got !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset_idle: got %h, want %h", got, IDLE);
        end
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < FRAME + 24; i++) begin
            er = exp_req(k);
            ed = exp_disp(k);
            gd = {DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
            n_checks++;
            if (oRequest !== er.req || (er.req && (oReqX !== er.x || oReqY !== er.y))) begin
                n_fail++;
                $display("FAIL after_reset_req k=%0d: got %b (%0d,%0d), want %b (%0d,%0d)",
                         k, oRequest, oReqX, oReqY, er.req, er.x, er.y);
            end
            n_checks++;
            if (gd !== ed) begin
                n_fail++;
                $display("FAIL after_reset_disp k=%0d: got %h, want %h", k, gd, ed);
            end
            tick();
        end
    endtask

`ifdef VIDEO_PATTERN_EN
    task automatic test_pattern();
        disp_t       ed, gd;
        logic [23:0] line0 [8];
        int          n_px;
        n_px = 0;
        run = 1'b0;
        repeat (2) tick();
        pat      = 1'b1;
        pat_mode = 1'b1;
        run      = 1'b1;
        for (int i = 0; i < FRAME + 24; i++) begin
            ed = exp_disp(k);
            gd = {DE, SYNC_H, SYNC_V, oFrameStart, oLineStart, oRed, oGreen, oBlue};
            if (DE && n_px < 8) begin
                line0[n_px] = {oRed, oGreen, oBlue};
                n_px++;
            end
            n_checks++;
            if (gd !== ed) begin
                n_fail++;
                $display("FAIL pattern_disp k=%0d: got %h, want %h", k, gd, ed);
            end
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (line0[j] !== BARS[j / 2]) begin
                n_fail++;
                $display("FAIL pattern_line0 px=%0d: got %h, want %h", j, line0[j], BARS[j / 2]);
            end
        end
        pat_mode = 1'b0;
        pat      = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        run = 1'b0;
        {ir, ig, ib} = 24'h0;
`ifdef VIDEO_PATTERN_EN
        pat = 1'b0;
`endif
        test_reset();
        test_raster();
        test_frame_period();
        test_run_drop();
        test_async_reset();
`ifdef VIDEO_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
